sol1_dma_ctrl: RTL and testbench
================================

// Module: sol1_dma_ctrl
// PURPOSE
//  Single-channel DMA engine: the requester side of the CPU's dma_req/dma_ack handshake.
//  CPU programs it through an 8-byte I/O register window (cpu_top bus cycles, DMA as responder).
//  When granted the bus, it copies LEN bytes from SRC to DST and raises a level IRQ on completion.
//  Its irq output feeds one irq_in bit of cpu_top.
// PARAMETERS
//  ADDR_W   22     bus address width; SRC/DST wrap mod 2**ADDR_W
//  IO_BASE  8'hE0  I/O window base; hit when addr[7:3]==IO_BASE[7:3] and mem_io==0
// PORTS
//  clk        in   1       system clock, single clock domain
//  arst       in   1       reset: synchronous, active-high
//  addr       in   ADDR_W  CPU address
//  cpu_wdata  in   8       CPU write data (cpu_top data_out)
//  rd, wr     in   1       CPU read/write strobes
//  mem_io     in   1       1=memory cycle, 0=I/O cycle
//  reg_hit    out  1       rd & I/O window hit; steers reg_rdata onto cpu_top data_in
//  reg_rdata  out  8       register read data, combinational from addr[2:0]
//  dma_req    out  1       bus request to CPU
//  dma_ack    in   1       bus grant from CPU
//  m_addr     out  ADDR_W  master address (valid while m_oe)
//  m_wdata    out  8       master write data
//  m_rd, m_wr out  1       master strobes; m_mem_io out 1 = always 1 (memory)
//  m_oe       out  1       master drives bus (1 in RD/WR states)
//  m_rdata    in   8       memory read data;  m_wait in 1 = extend current phase
//  irq        out  1       done & IRQ_EN, level
// BEHAVIOUR
//  Regs (offset): 0-2 SRC[7:0],[15:8],[21:16]; 3-5 DST same; 6 LEN (0 = 256 bytes);
//   7 CTRL: wr b0 START, b1 IRQ_EN, b7=1 clears DONE, b6=1 clears ERR;
//   rd b0 BUSY, b1 IRQ_EN, b6 ERR, b7 DONE. Unused bits read 0; SRC/DST hi bits [7:6] read 0.
//  Writes commit at the clk edge with wr & hit. While BUSY: writes to 0-6 ignored; START ignored;
//   only clear bits of CTRL act. Reads: zero-latency, combinational.
//  FSM IDLE->REQ on START write (BUSY=1; START with LEN any value accepted).
//   REQ: dma_req=1; on dma_ack=1 -> RD next cycle.
//   RD: m_oe=1, m_rd=1, m_addr=SRC; hold while m_wait=1; first cycle with m_wait=0 latch
//    m_rdata into buffer -> WR.
//   WR: m_wr=1, m_addr=DST, m_wdata=buffer; on m_wait=0: SRC+=1, DST+=1 (wrap at 2**ADDR_W),
//    remaining-=1; remaining==0 -> DONE else RD. Bus kept for whole burst (no re-request).
//   DONE: dma_req=0, m_oe=0, DONE=1, BUSY=0 -> IDLE.
//  Minimum 2 cycles/byte; m_wait stretches each phase by one cycle per asserted cycle.
//  dma_ack falling during RD/WR: abort same cycle, all m_* =0, dma_req=0, ERR=1, BUSY=0, IDLE;
//   SRC/DST/remaining keep partial values (readable).
//  DONE set and CTRL clear-DONE in same cycle: set wins.
//  Reset (any state): regs, buffer, flags 0; dma_req, m_*, irq, reg_hit 0; state IDLE.
//   Outputs reach reset value the cycle after arst sampled high.
// STRUCTURE
//  sol1_bus_pkg: dma_state_t enum {IDLE,REQ,RD,WR,DONE}, register offsets,
//   CTRL bit indices, BUS_ADDR_W=22.
//  Sub-module sol1_dma_regs: register file, window decode, read mux, clear/set priority.
//  sol1_dma_ctrl: FSM, address counters, byte buffer, master outputs.
// TESTING
//  1 Program SRC=0x000100, DST=0x000200, LEN=3, START; ack 2 cycles after req, m_wait=0
//    -> 3 RD/WR pairs at 0x100->0x200..0x102->0x202, 6 bus cycles, DONE=1, dma_req drops.
//  2 IRQ_EN=1, LEN=1 -> irq rises with DONE; write CTRL=0x80 -> irq and DONE=0 next cycle.
//  3 m_wait high 2 cycles in each RD -> each byte takes 4 cycles, data intact.
//  4 SRC=0x3FFFFF, DST=0x000010, LEN=2 -> second read at 0x000000 (wrap).
//  5 dma_ack dropped mid-WR -> ERR=1, BUSY=0, m_oe=0 same cycle; START while BUSY ignored.
//  6 arst during RD -> all outputs 0 next cycle; LEN=0 -> 256 bytes moved.

Source files
------------

// File: rtl/sol1_bus_pkg.sv
// Shared definitions for the sol1 DMA block: FSM states, register map, CTRL bits.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sol1_bus_pkg;

    localparam int         BUS_ADDR_W   = 22;
    localparam logic [7:0] IO_BASE_DFLT = 8'hE0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } dma_state_t;

    // Register offsets inside the 8-byte I/O window
    localparam logic [2:0] OFF_SRC0 = 3'd0;
    localparam logic [2:0] OFF_SRC1 = 3'd1;
    localparam logic [2:0] OFF_SRC2 = 3'd2;
    localparam logic [2:0] OFF_DST0 = 3'd3;
    localparam logic [2:0] OFF_DST1 = 3'd4;
    localparam logic [2:0] OFF_DST2 = 3'd5;
    localparam logic [2:0] OFF_LEN  = 3'd6;
    localparam logic [2:0] OFF_CTRL = 3'd7;

    // CTRL bit positions (write side: START/IRQ_EN/clear bits, read side: status)
    localparam int CTRL_START  = 0;
    localparam int CTRL_BUSY   = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ERR    = 6;
    localparam int CTRL_DONE   = 7;

    // I/O window decode: only the low address byte takes part.
    function automatic logic io_window_hit(input logic [7:0] a, input logic [7:0] base,
                                           input logic mem_io);
        return (a[7:3] == base[7:3]) && !mem_io;
    endfunction

endpackage

// File: rtl/sol1_dma_regs.sv
// Register file for the DMA channel: window decode, read mux, SRC/DST/LEN counters, DONE/ERR flags.
// Latency: reads are combinational; writes commit on the clk edge with wr & hit.
// Backpressure: none; CPU accesses always complete, writes to 0-6 are dropped while busy.
// Ports: CPU side (addr_lo, cpu_wdata, rd, wr, mem_io, reg_hit, reg_rdata); FSM side
//   (busy, step, done_set, err_set in; start, src, dst, len out); irq level out.
module sol1_dma_regs
    import sol1_bus_pkg::*;
#(
    parameter int         ADDR_W  = BUS_ADDR_W,
    parameter logic [7:0] IO_BASE = IO_BASE_DFLT
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [7:0]        addr_lo,
    input  logic [7:0]        cpu_wdata,
    input  logic              rd,
    input  logic              wr,
    input  logic              mem_io,
    input  logic              busy,
    input  logic              step,
    input  logic              done_set,
    input  logic              err_set,
    output logic              reg_hit,
    output logic [7:0]        reg_rdata,
    output logic              start,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [7:0]        len,
    output logic              irq
);

    logic       hit;
    logic       wr_en;
    logic       ctrl_wr;
    logic [2:0] off;
    logic       done;
    logic       err;
    logic       irq_en;

    assign off     = addr_lo[2:0];
    assign hit     = io_window_hit(addr_lo, IO_BASE, mem_io);
    assign wr_en   = wr && hit;
    assign ctrl_wr = wr_en && (off == OFF_CTRL);
    assign reg_hit = rd && hit;
    assign start   = ctrl_wr && !busy && cpu_wdata[CTRL_START];
    assign irq     = done && irq_en;

    // LEN doubles as the remaining-byte counter; 0 means 256 because the
    // FSM finishes on the step taken while it reads 1.
    always_ff @(posedge clk) begin
        if (arst) begin
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            irq_en <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (step) begin
                src <= src + 1'b1;
                dst <= dst + 1'b1;
                len <= len - 8'd1;
            end else if (wr_en && !busy) begin
                case (off)
                    OFF_SRC0: src[7:0]         <= cpu_wdata;
                    OFF_SRC1: src[15:8]        <= cpu_wdata;
                    OFF_SRC2: src[ADDR_W-1:16] <= cpu_wdata[ADDR_W-17:0];
                    OFF_DST0: dst[7:0]         <= cpu_wdata;
                    OFF_DST1: dst[15:8]        <= cpu_wdata;
                    OFF_DST2: dst[ADDR_W-1:16] <= cpu_wdata[ADDR_W-17:0];
                    OFF_LEN:  len              <= cpu_wdata;
                    default:  ;
                endcase
            end

            if (ctrl_wr && !busy) begin
                irq_en <= cpu_wdata[CTRL_IRQ_EN];
            end

            // Hardware set beats a software clear landing on the same edge.
            if (done_set) begin
                done <= 1'b1;
            end else if (ctrl_wr && cpu_wdata[CTRL_DONE]) begin
                done <= 1'b0;
            end

            if (err_set) begin
                err <= 1'b1;
            end else if (ctrl_wr && cpu_wdata[CTRL_ERR]) begin
                err <= 1'b0;
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (off)
            OFF_SRC0: reg_rdata = src[7:0];
            OFF_SRC1: reg_rdata = src[15:8];
            OFF_SRC2: reg_rdata = 8'(src[ADDR_W-1:16]);
            OFF_DST0: reg_rdata = dst[7:0];
            OFF_DST1: reg_rdata = dst[15:8];
            OFF_DST2: reg_rdata = 8'(dst[ADDR_W-1:16]);
            OFF_LEN:  reg_rdata = len;
            OFF_CTRL: begin
                reg_rdata[CTRL_DONE]   = done;
                reg_rdata[CTRL_ERR]    = err;
                reg_rdata[CTRL_IRQ_EN] = irq_en;
                reg_rdata[CTRL_BUSY]   = busy;
            end
            default:  reg_rdata = '0;
        endcase
    end

endmodule

// File: rtl/sol1_dma_ctrl.sv
// Single-channel DMA: requests the CPU bus, copies LEN bytes SRC->DST, raises a level irq when done.
// Latency: one REQ cycle minimum before the grant is used, then 2 cycles/byte plus one per m_wait cycle.
// Backpressure: m_wait holds the current RD/WR phase; losing dma_ack mid-burst aborts with ERR.
// Ports: clk/arst; CPU register window (addr, cpu_wdata, rd, wr, mem_io, reg_hit, reg_rdata);
//   bus handshake (dma_req, dma_ack); master bus (m_addr, m_wdata, m_rd, m_wr, m_mem_io, m_oe,
//   m_rdata, m_wait); irq.
module sol1_dma_ctrl
    import sol1_bus_pkg::*;
#(
    parameter int         ADDR_W  = BUS_ADDR_W,
    parameter logic [7:0] IO_BASE = IO_BASE_DFLT
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              rd,
    input  logic              wr,
    input  logic              mem_io,
    output logic              reg_hit,
    output logic [7:0]        reg_rdata,
    output logic              dma_req,
    input  logic              dma_ack,
    output logic [ADDR_W-1:0] m_addr,
    output logic [7:0]        m_wdata,
    output logic              m_rd,
    output logic              m_wr,
    output logic              m_mem_io,
    output logic              m_oe,
    input  logic [7:0]        m_rdata,
    input  logic              m_wait,
    output logic              irq
);

    dma_state_t        state;
    dma_state_t        state_nxt;
    logic [7:0]        buffer;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [7:0]        len;
    logic              busy;
    logic              start;
    logic              on_bus;
    logic              abort;
    logic              rd_done;
    logic              wr_done;
    logic              last_byte;
    logic              unused_addr_hi;

    // Window decode only looks at the low address byte.
    assign unused_addr_hi = ^addr[ADDR_W-1:8];

    assign busy      = (state == ST_REQ) || (state == ST_RD) || (state == ST_WR);
    assign on_bus    = (state == ST_RD) || (state == ST_WR);
    assign abort     = on_bus && !dma_ack;
    assign rd_done   = (state == ST_RD) && dma_ack && !m_wait;
    assign wr_done   = (state == ST_WR) && dma_ack && !m_wait;
    assign last_byte = (len == 8'd1);

    sol1_dma_regs #(
        .ADDR_W  (ADDR_W),
        .IO_BASE (IO_BASE)
    ) u_regs (
        .clk       (clk),
        .arst      (arst),
        .addr_lo   (addr[7:0]),
        .cpu_wdata (cpu_wdata),
        .rd        (rd),
        .wr        (wr),
        .mem_io    (mem_io),
        .busy      (busy),
        .step      (wr_done),
        .done_set  (wr_done && last_byte),
        .err_set   (abort),
        .reg_hit   (reg_hit),
        .reg_rdata (reg_rdata),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .irq       (irq)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_REQ;
            ST_REQ:  if (dma_ack) state_nxt = ST_RD;
            ST_RD: begin
                if (!dma_ack)     state_nxt = ST_IDLE;
                else if (!m_wait) state_nxt = ST_WR;
            end
            ST_WR: begin
                if (!dma_ack)     state_nxt = ST_IDLE;
                else if (!m_wait) state_nxt = last_byte ? ST_DONE : ST_RD;
            end
            // START is accepted here too since BUSY already reads 0.
            ST_DONE: state_nxt = start ? ST_REQ : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state  <= ST_IDLE;
            buffer <= '0;
        end else begin
            state <= state_nxt;
            if (rd_done) begin
                buffer <= m_rdata;
            end
        end
    end

    // Master outputs are gated by dma_ack so an abort releases the bus in
    // the same cycle the grant disappears.
    assign m_oe     = on_bus && dma_ack;
    assign m_rd     = (state == ST_RD) && dma_ack;
    assign m_wr     = (state == ST_WR) && dma_ack;
    assign m_addr   = m_rd ? src : (m_wr ? dst : '0);
    assign m_wdata  = m_wr ? buffer : '0;
    assign m_mem_io = 1'b1;
    assign dma_req  = (state == ST_REQ) || m_oe;

endmodule

// File: tb/tb_sol1_dma_ctrl.sv
module tb_sol1_dma_ctrl;

    localparam int         AW     = 22;
    localparam logic [4:0] IOB_HI = 5'b11100;
    localparam logic [2:0] R_SRC  = 3'd0;
    localparam logic [2:0] R_DST  = 3'd3;
    localparam logic [2:0] R_LEN  = 3'd6;
    localparam logic [2:0] R_CTRL = 3'd7;

    logic          clk = 1'b0;
    logic          arst;
    logic [AW-1:0] addr;
    logic [7:0]    cpu_wdata;
    logic          rd, wr, mem_io;
    logic          reg_hit;
    logic [7:0]    reg_rdata;
    logic          dma_req, dma_ack;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_wdata, m_rdata;
    logic          m_rd, m_wr, m_mem_io, m_oe;
    logic          m_wait = 1'b0;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    // Bus-side models: arbiter, wait generator, memory with address-derived data.
    logic          ack_q    = 1'b0;
    logic          drop_ack = 1'b0;
    int            ack_delay = 2;
    int            wait_mode = 0;
    int            req_cnt = 0;
    int            rd_wait_cnt = 0;
    int            oe_cycles = 0;
    logic [AW-1:0] rd_log[$];
    logic [AW-1:0] wr_addr_log[$];
    logic [7:0]    wr_dat_log[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ {a[12:8], a[15:13]} ^ {2'b00, a[21:16]} ^ 8'h5A;
    endfunction

    assign m_rdata = pat(m_addr);
    assign dma_ack = ack_q && !drop_ack;

    sol1_dma_ctrl dut (
        .clk       (clk),
        .arst      (arst),
        .addr      (addr),
        .cpu_wdata (cpu_wdata),
        .rd        (rd),
        .wr        (wr),
        .mem_io    (mem_io),
        .reg_hit   (reg_hit),
        .reg_rdata (reg_rdata),
        .dma_req   (dma_req),
        .dma_ack   (dma_ack),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rd      (m_rd),
        .m_wr      (m_wr),
        .m_mem_io  (m_mem_io),
        .m_oe      (m_oe),
        .m_rdata   (m_rdata),
        .m_wait    (m_wait),
        .irq       (irq)
    );

    always @(negedge clk) begin
        if (!dma_req) begin
            ack_q   = 1'b0;
            req_cnt = 0;
        end else if (!ack_q) begin
            req_cnt++;
            if (req_cnt >= ack_delay) ack_q = 1'b1;
        end
        case (wait_mode)
            0: m_wait = 1'b0;
            1: begin
                if (m_rd) begin
                    m_wait = (rd_wait_cnt < 2);
                    rd_wait_cnt++;
                end else begin
                    m_wait = 1'b0;
                    rd_wait_cnt = 0;
                end
            end
            default: m_wait = m_oe && ($urandom_range(0, 2) == 0);
        endcase
        if (m_oe) oe_cycles++;
        if (m_rd && !m_wait) rd_log.push_back(m_addr);
        if (m_wr && !m_wait) begin
            wr_addr_log.push_back(m_addr);
            wr_dat_log.push_back(m_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] off, input logic [7:0] d);
        @(negedge clk);
        addr = {14'h0, IOB_HI, off}; cpu_wdata = d; mem_io = 1'b0; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] off, output logic [7:0] d);
        @(negedge clk);
        addr = {14'h0, IOB_HI, off}; mem_io = 1'b0; rd = 1'b1;
        #1 d = reg_rdata;
        rd = 1'b0;
    endtask

    task automatic rd_addr(input logic [2:0] base, output logic [23:0] v);
        logic [7:0] b0, b1, b2;
        rd_reg(base, b0);
        rd_reg(base + 3'd1, b1);
        rd_reg(base + 3'd2, b2);
        v = {b2, b1, b0};
    endtask

    task automatic prog(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [7:0] l);
        wr_reg(3'd0, s[7:0]);
        wr_reg(3'd1, s[15:8]);
        wr_reg(3'd2, {2'b00, s[21:16]});
        wr_reg(3'd3, d[7:0]);
        wr_reg(3'd4, d[15:8]);
        wr_reg(3'd5, {2'b00, d[21:16]});
        wr_reg(3'd6, l);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic [7:0] d;
        d = 8'hFF;
        for (int c = 0; c < budget; c++) begin
            rd_reg(R_CTRL, d);
            if (!d[0]) break;
        end
        chk({tag, "_idle"}, 32'(d[0]), 32'd0);
    endtask

    task automatic wait_bus(input string tag, input bit want_wr, input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (want_wr ? m_wr : m_rd) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    // Program, start, wait, then compare the bus trace and final registers
    // against addresses computed as base+i modulo 2**22.
    task automatic run_xfer(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [7:0] l, input logic [7:0] ctrl);
        int            n;
        logic [23:0]   v;
        logic [7:0]    r;
        logic [AW-1:0] ea;
        n = (l == 8'd0) ? 256 : int'(l);
        prog(s, d, l);
        rd_log.delete(); wr_addr_log.delete(); wr_dat_log.delete();
        oe_cycles = 0;
        wr_reg(R_CTRL, ctrl);
        wait_idle(tag, n * 8 + 50);
        chk({tag, "_nrd"}, 32'(rd_log.size()), 32'(n));
        chk({tag, "_nwr"}, 32'(wr_addr_log.size()), 32'(n));
        for (int i = 0; i < n && i < rd_log.size() && i < wr_addr_log.size(); i++) begin
            ea = s + AW'(i);
            chk({tag, "_raddr"}, 32'(rd_log[i]), 32'(ea));
            chk({tag, "_wdata"}, 32'(wr_dat_log[i]), 32'(pat(ea)));
            ea = d + AW'(i);
            chk({tag, "_waddr"}, 32'(wr_addr_log[i]), 32'(ea));
        end
        ea = s + AW'(n);
        rd_addr(R_SRC, v);
        chk({tag, "_src_end"}, 32'(v), 32'({2'b00, ea}));
        ea = d + AW'(n);
        rd_addr(R_DST, v);
        chk({tag, "_dst_end"}, 32'(v), 32'({2'b00, ea}));
        rd_reg(R_LEN, r);
        chk({tag, "_len_end"}, 32'(r), 32'd0);
        rd_reg(R_CTRL, r);
        chk({tag, "_ctrl_end"}, 32'(r), 32'({1'b1, 5'b0, ctrl[1], 1'b0}));
        chk({tag, "_req_low"}, 32'(dma_req), 32'd0);
    endtask

    initial begin
        logic [7:0]    r;
        logic [23:0]   v;
        logic [AW-1:0] s, d;
        logic [7:0]    l;

        arst = 1'b1; addr = '0; cpu_wdata = '0; rd = 1'b0; wr = 1'b0; mem_io = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;

        // Reset state
        #1;
        chk("rst_outs", 32'({dma_req, m_oe, m_rd, m_wr, irq, reg_hit}), 32'd0);
        chk("rst_maddr", 32'({m_addr, m_wdata}), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_reg(3'(i), r);
            chk("rst_reg", 32'(r), 32'd0);
        end
        @(negedge clk);
        addr = {14'h0, IOB_HI, 3'd5}; mem_io = 1'b0; rd = 1'b1;
        #1 chk("hit_io", 32'(reg_hit), 32'd1);
        mem_io = 1'b1;
        #1 chk("miss_mem", 32'(reg_hit), 32'd0);
        mem_io = 1'b0; addr = 22'h0000D8;
        #1 chk("miss_addr", 32'(reg_hit), 32'd0);
        rd = 1'b0;

        // Basic 3-byte copy, ack two cycles after request
        ack_delay = 2; wait_mode = 0;
        run_xfer("t1", 22'h000100, 22'h000200, 8'd3, 8'h01);
        chk("t1_oe_cycles", 32'(oe_cycles), 32'd6);

        // IRQ on completion, then clear DONE
        run_xfer("t2", 22'h001000, 22'h002000, 8'd1, 8'h83);
        #1 chk("t2_irq_hi", 32'(irq), 32'd1);
        wr_reg(R_CTRL, 8'h82);
        #1 chk("t2_irq_lo", 32'(irq), 32'd0);
        rd_reg(R_CTRL, r);
        chk("t2_ctrl_clr", 32'(r), 32'h02);

        // DONE set and clear on the same edge: set wins
        prog(22'h000040, 22'h000080, 8'd1);
        wr_reg(R_CTRL, 8'h03);
        wait_bus("t2b", 1'b1, 40);
        addr = {14'h0, IOB_HI, R_CTRL}; cpu_wdata = 8'h80; mem_io = 1'b0; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        rd_reg(R_CTRL, r);
        chk("t2b_set_wins", 32'(r), 32'h82);
        chk("t2b_irq", 32'(irq), 32'd1);
        wr_reg(R_CTRL, 8'h80);

        // Two wait cycles on every read phase
        wait_mode = 1;
        s = AW'($urandom); d = AW'($urandom);
        run_xfer("t3", s, d, 8'd4, 8'h01);
        chk("t3_oe_cycles", 32'(oe_cycles), 32'd16);
        chk("t3_memio", 32'(m_mem_io), 32'd1);

        // Source address wrap
        wait_mode = 0;
        run_xfer("t4", 22'h3FFFFF, 22'h000010, 8'd2, 8'h01);

        // Abort mid-write; writes and START while busy are ignored
        ack_delay = 6;
        prog(22'h001234, 22'h005678, 8'd4);
        wr_reg(R_CTRL, 8'hC1);
        wr_reg(R_SRC, 8'hAA);
        wr_reg(R_LEN, 8'h11);
        wr_reg(R_CTRL, 8'h03);
        wait_bus("t5_wr1", 1'b1, 40);
        wait_bus("t5_wr2", 1'b1, 40);
        drop_ack = 1'b1;
        #1 chk("t5_bus_rel", 32'({m_oe, m_rd, m_wr, dma_req}), 32'd0);
        rd_reg(R_CTRL, r);
        chk("t5_ctrl_err", 32'(r), 32'h40);
        rd_addr(R_SRC, v);
        chk("t5_src_part", 32'(v), 32'h001235);
        rd_addr(R_DST, v);
        chk("t5_dst_part", 32'(v), 32'h005679);
        rd_reg(R_LEN, r);
        chk("t5_len_part", 32'(r), 32'd3);
        chk("t5_req_low", 32'(dma_req), 32'd0);
        drop_ack = 1'b0;
        wr_reg(R_CTRL, 8'h40);
        rd_reg(R_CTRL, r);
        chk("t5_err_clr", 32'(r), 32'h00);

        // Reset in the middle of a read phase
        ack_delay = 1;
        prog(22'h000300, 22'h000400, 8'd5);
        wr_reg(R_CTRL, 8'h03);
        wait_bus("t6_rd", 1'b0, 40);
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        #1;
        chk("t6_rst_outs", 32'({dma_req, m_oe, m_rd, m_wr, irq}), 32'd0);
        chk("t6_rst_maddr", 32'({m_addr, m_wdata}), 32'd0);
        rd_addr(R_SRC, v);
        chk("t6_rst_src", 32'(v), 32'd0);
        rd_reg(R_CTRL, r);
        chk("t6_rst_ctrl", 32'(r), 32'd0);

        // LEN=0 moves 256 bytes, random waits
        wait_mode = 2;
        run_xfer("t6_256", 22'h010000, 22'h3FFF80, 8'd0, 8'h01);

        // Randomised transfers
        for (int k = 0; k < 5; k++) begin
            wait_mode = int'($urandom_range(0, 2));
            ack_delay = int'($urandom_range(1, 4));
            s = AW'($urandom); d = AW'($urandom);
            if (k == 0) s = 22'h3FFFF8;
            l = 8'($urandom_range(1, 24));
            run_xfer("rnd", s, d, l, 8'($urandom_range(0, 1) << 1) | 8'h81);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
